// File: rtl/hit_resolver_if.sv
// Bus bundle for hit_resolver: per-frame player boxes and states in,
// registered hit result, event strobes and hitstun flags out.
interface hit_resolver_if #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned NBOX    = 2,
  parameter int unsigned STATE_W = 4
);
  logic                        frame_tick;
  logic [STATE_W-1:0]          p1_state;
  logic [STATE_W-1:0]          p2_state;
  logic [NBOX*4*COORD_W-1:0]   p1_hitbox;
  logic [NBOX*4*COORD_W-1:0]   p2_hitbox;
  logic [NBOX-1:0]             p1_hitbox_valid;
  logic [NBOX-1:0]             p2_hitbox_valid;
  logic [4*COORD_W-1:0]        p1_hurtbox;
  logic [4*COORD_W-1:0]        p2_hurtbox;
  logic [1:0]                  hitresult;
  logic                        p1_hit_pulse;
  logic                        p2_hit_pulse;
  logic                        clash_pulse;
  logic                        p1_stun;
  logic                        p2_stun;

  modport master (
    output frame_tick, p1_state, p2_state, p1_hitbox, p2_hitbox,
           p1_hitbox_valid, p2_hitbox_valid, p1_hurtbox, p2_hurtbox,
    input  hitresult, p1_hit_pulse, p2_hit_pulse, clash_pulse, p1_stun, p2_stun
  );

  modport slave (
    input  frame_tick, p1_state, p2_state, p1_hitbox, p2_hitbox,
           p1_hitbox_valid, p2_hitbox_valid, p1_hurtbox, p2_hurtbox,
    output hitresult, p1_hit_pulse, p2_hit_pulse, clash_pulse, p1_stun, p2_stun
  );
endinterface

// File: rtl/hit_resolver.sv
// Per-frame hit resolution between two players: box overlap, one hit per
// attack (ARMED/SPENT), clash detection and hitstun countdown.
module hit_resolver #(
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned NBOX        = 2,
  parameter int unsigned STATE_W     = 4,
  parameter int unsigned STUN_FRAMES = 16
) (
  input logic          clk,
  input logic          rst_n,
  hit_resolver_if.slave bus
);
  localparam int unsigned BOX_W = 4 * COORD_W;
  localparam logic [STATE_W-1:0] ST_START = STATE_W'(3);
  localparam logic [STATE_W-1:0] ST_END   = STATE_W'(4);
  localparam logic [STATE_W-1:0] ST_PULL  = STATE_W'(5);
  localparam logic [7:0]         STUN_LOAD = 8'(STUN_FRAMES);

  typedef enum logic {ARMED = 1'b0, SPENT = 1'b1} atk_t;

  atk_t       p1_atk, p1_atk_nxt, p2_atk, p2_atk_nxt;
  logic [7:0] p1_cnt, p1_cnt_nxt, p2_cnt, p2_cnt_nxt;
  logic [1:0] result, result_nxt;
  logic       p1_pulse, p1_pulse_nxt, p2_pulse, p2_pulse_nxt, clash, clash_nxt;
  logic       p1_conn, p2_conn;

  // Malformed boxes (x1>x2 or y1>y2) never overlap anything.
  function automatic logic overlap(input logic [BOX_W-1:0] a, input logic [BOX_W-1:0] b);
    logic [COORD_W-1:0] ax1, ax2, ay1, ay2, bx1, bx2, by1, by2;
    {ax1, ax2, ay1, ay2} = a;
    {bx1, bx2, by1, by2} = b;
    return (ax1 <= ax2) && (ay1 <= ay2) && (bx1 <= bx2) && (by1 <= by2) &&
           (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
  endfunction

  // Target is the defender's own hitboxes while it is mid-swing, else its hurtbox.
  function automatic logic lands(
    input logic [NBOX*BOX_W-1:0] hb,
    input logic [NBOX-1:0]       hv,
    input logic [STATE_W-1:0]    tstate,
    input logic [NBOX*BOX_W-1:0] thb,
    input logic [NBOX-1:0]       thv,
    input logic [BOX_W-1:0]      hurt
  );
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NBOX; i++) begin
      if (hv[i]) begin
        if (tstate == ST_END || tstate == ST_PULL) begin
          for (int unsigned j = 0; j < NBOX; j++)
            if (thv[j] && overlap(hb[i*BOX_W +: BOX_W], thb[j*BOX_W +: BOX_W])) hit = 1'b1;
        end else if (overlap(hb[i*BOX_W +: BOX_W], hurt)) begin
          hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  function automatic logic in_attack(input logic [STATE_W-1:0] s);
    return (s == ST_START) || (s == ST_END) || (s == ST_PULL);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_atk   <= ARMED;
      p2_atk   <= ARMED;
      p1_cnt   <= '0;
      p2_cnt   <= '0;
      result   <= '0;
      p1_pulse <= 1'b0;
      p2_pulse <= 1'b0;
      clash    <= 1'b0;
    end else begin
      p1_atk   <= p1_atk_nxt;
      p2_atk   <= p2_atk_nxt;
      p1_cnt   <= p1_cnt_nxt;
      p2_cnt   <= p2_cnt_nxt;
      result   <= result_nxt;
      p1_pulse <= p1_pulse_nxt;
      p2_pulse <= p2_pulse_nxt;
      clash    <= clash_nxt;
    end
  end

  always_comb begin
    p1_atk_nxt   = p1_atk;
    p2_atk_nxt   = p2_atk;
    p1_cnt_nxt   = p1_cnt;
    p2_cnt_nxt   = p2_cnt;
    result_nxt   = result;
    p1_pulse_nxt = 1'b0;
    p2_pulse_nxt = 1'b0;
    clash_nxt    = 1'b0;

    p1_conn = bus.frame_tick && (bus.p1_state == ST_END) && (p1_atk == ARMED) &&
              (p2_cnt == '0) &&
              lands(bus.p1_hitbox, bus.p1_hitbox_valid, bus.p2_state,
                    bus.p2_hitbox, bus.p2_hitbox_valid, bus.p2_hurtbox);
    p2_conn = bus.frame_tick && (bus.p2_state == ST_END) && (p2_atk == ARMED) &&
              (p1_cnt == '0) &&
              lands(bus.p2_hitbox, bus.p2_hitbox_valid, bus.p1_state,
                    bus.p1_hitbox, bus.p1_hitbox_valid, bus.p1_hurtbox);

    if (bus.frame_tick) begin
      result_nxt   = {p1_conn, p2_conn};
      p2_pulse_nxt = p1_conn && !p2_conn;
      p1_pulse_nxt = p2_conn && !p1_conn;
      clash_nxt    = p1_conn && p2_conn;

      if (p2_pulse_nxt)       p2_cnt_nxt = STUN_LOAD;
      else if (p2_cnt != '0)  p2_cnt_nxt = p2_cnt - 8'd1;
      if (p1_pulse_nxt)       p1_cnt_nxt = STUN_LOAD;
      else if (p1_cnt != '0)  p1_cnt_nxt = p1_cnt - 8'd1;

      case (p1_atk)
        ARMED: if (p1_conn) p1_atk_nxt = SPENT;
        SPENT: if (!in_attack(bus.p1_state)) p1_atk_nxt = ARMED;
        default: p1_atk_nxt = ARMED;
      endcase
      case (p2_atk)
        ARMED: if (p2_conn) p2_atk_nxt = SPENT;
        SPENT: if (!in_attack(bus.p2_state)) p2_atk_nxt = ARMED;
        default: p2_atk_nxt = ARMED;
      endcase
    end
  end

  assign bus.hitresult    = result;
  assign bus.p1_hit_pulse = p1_pulse;
  assign bus.p2_hit_pulse = p2_pulse;
  assign bus.clash_pulse  = clash;
  assign bus.p1_stun      = (p1_cnt != '0);
  assign bus.p2_stun      = (p2_cnt != '0);
endmodule

// File: tb/tb_hit_resolver.sv
// Self-checking bench for hit_resolver: directed scenarios with literal
// expectations plus randomized frames checked against a behavioural model.
module tb_hit_resolver;
  localparam int CW = 10;
  localparam int NB = 2;
  localparam int SW = 4;
  localparam int BW = 4 * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hit_resolver_if #(.COORD_W(CW), .NBOX(NB), .STATE_W(SW)) bus();
  hit_resolver #(.COORD_W(CW), .NBOX(NB), .STATE_W(SW), .STUN_FRAMES(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk(input int x1, input int x2, input int y1, input int y2);
    logic [CW-1:0] a, b, c, d;
    a = x1[CW-1:0]; b = x2[CW-1:0]; c = y1[CW-1:0]; d = y2[CW-1:0];
    return {a, b, c, d};
  endfunction

  // ---------------- behavioural model ----------------
  int                m_st [2];
  logic [NB*BW-1:0]  m_hb [2];
  logic [NB-1:0]     m_hv [2];
  logic [BW-1:0]     m_hu [2];
  bit                armed [2];
  int                stun [2];
  logic [1:0]        m_res;
  bit                m_hitp [2];
  bit                m_clash;

  function automatic bit box_ovl(input logic [BW-1:0] a, input logic [BW-1:0] b);
    int ax1, ax2, ay1, ay2, bx1, bx2, by1, by2;
    ax1 = int'(a[39:30]); ax2 = int'(a[29:20]); ay1 = int'(a[19:10]); ay2 = int'(a[9:0]);
    bx1 = int'(b[39:30]); bx2 = int'(b[29:20]); by1 = int'(b[19:10]); by2 = int'(b[9:0]);
    if (ax1 > ax2 || ay1 > ay2 || bx1 > bx2 || by1 > by2) return 0;
    return ax1 <= bx2 && bx1 <= ax2 && ay1 <= by2 && by1 <= ay2;
  endfunction

  function automatic bit lands(input int p);
    int q = 1 - p;
    for (int i = 0; i < NB; i++) begin
      if (!m_hv[p][i]) continue;
      if (m_st[q] == 4 || m_st[q] == 5) begin
        for (int j = 0; j < NB; j++)
          if (m_hv[q][j] && box_ovl(m_hb[p][i*BW +: BW], m_hb[q][j*BW +: BW])) return 1;
      end else if (box_ovl(m_hb[p][i*BW +: BW], m_hu[q])) return 1;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit conn [2];
    if (!rst_n) begin
      armed = '{1, 1}; stun = '{0, 0}; m_res = 2'b00;
      m_hitp = '{0, 0}; m_clash = 0;
    end else begin
      m_hitp = '{0, 0}; m_clash = 0;
      if (bus.frame_tick) begin
        m_st[0] = int'(bus.p1_state);   m_st[1] = int'(bus.p2_state);
        m_hb[0] = bus.p1_hitbox;        m_hb[1] = bus.p2_hitbox;
        m_hv[0] = bus.p1_hitbox_valid;  m_hv[1] = bus.p2_hitbox_valid;
        m_hu[0] = bus.p1_hurtbox;       m_hu[1] = bus.p2_hurtbox;
        for (int p = 0; p < 2; p++)
          conn[p] = m_st[p] == 4 && armed[p] && stun[1-p] == 0 && lands(p);
        m_res = {conn[0], conn[1]};
        m_clash = conn[0] && conn[1];
        m_hitp[1] = conn[0] && !conn[1];
        m_hitp[0] = conn[1] && !conn[0];
        for (int p = 0; p < 2; p++) begin
          if (m_hitp[p]) stun[p] = 16;
          else if (stun[p] > 0) stun[p]--;
          if (conn[p]) armed[p] = 0;
          else if (!(m_st[p] inside {3, 4, 5})) armed[p] = 1;
        end
      end
    end
  end

  // single compare process, away from the active edge
  always @(negedge clk) begin
    chk("hitresult", 32'(bus.hitresult), 32'(m_res));
    chk("p1_hit_pulse", 32'(bus.p1_hit_pulse), 32'(m_hitp[0]));
    chk("p2_hit_pulse", 32'(bus.p2_hit_pulse), 32'(m_hitp[1]));
    chk("clash_pulse", 32'(bus.clash_pulse), 32'(m_clash));
    chk("p1_stun", 32'(bus.p1_stun), 32'(stun[0] != 0));
    chk("p2_stun", 32'(bus.p2_stun), 32'(stun[1] != 0));
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    bus.frame_tick = 0;
    bus.p1_state = '0; bus.p2_state = '0;
    bus.p1_hitbox = '0; bus.p2_hitbox = '0;
    bus.p1_hitbox_valid = '0; bus.p2_hitbox_valid = '0;
    bus.p1_hurtbox = mk(900, 950, 900, 950);
    bus.p2_hurtbox = mk(900, 950, 900, 950);
  endtask

  task automatic step(input bit t);
    bus.frame_tick = t;
    @(posedge clk);
    #2;
    bus.frame_tick = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  task automatic setup_basic();
    clear_inputs();
    bus.p1_state = 4'd4;
    bus.p1_hitbox = {mk(0, 0, 0, 0), mk(100, 140, 50, 80)};
    bus.p1_hitbox_valid = 2'b01;
    bus.p2_hurtbox = mk(140, 180, 40, 120);
  endtask

  function automatic logic [BW-1:0] rand_box();
    int a = $urandom_range(0, 63), b = $urandom_range(0, 63);
    int c = $urandom_range(0, 63), d = $urandom_range(0, 63);
    if ($urandom_range(0, 9) != 0) begin
      if (a > b) begin int t = a; a = b; b = t; end
      if (c > d) begin int t = c; c = d; d = t; end
    end
    return mk(a, b, c, d);
  endfunction

  function automatic logic [SW-1:0] rand_state();
    case ($urandom_range(0, 6))
      0: return 4'd0;
      1: return 4'd3;
      2, 3, 4: return 4'd4;
      5: return 4'd5;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int n;
    clear_inputs();
    rst_n = 0;
    #1;
    chk("reset_hitresult", 32'(bus.hitresult), 0);
    chk("reset_stun", 32'({bus.p1_stun, bus.p2_stun}), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // basic hit, first evaluation only on a tick, 16-tick stun
    setup_basic();
    step(0); step(0);
    chk("no_eval_without_tick", 32'(bus.hitresult), 0);
    step(1);
    chk("req028_result", 32'(bus.hitresult), 32'h2);
    chk("req028_pulse", 32'(bus.p2_hit_pulse), 1);
    chk("req028_stun", 32'(bus.p2_stun), 1);
    step(0);
    chk("req028_pulse_one_cycle", 32'(bus.p2_hit_pulse), 0);
    chk("req028_result_holds", 32'(bus.hitresult), 32'h2);
    bus.p1_state = 4'd0;
    repeat (15) step(1);
    chk("req028_stun_tick15", 32'(bus.p2_stun), 1);
    step(1);
    chk("req028_stun_tick16", 32'(bus.p2_stun), 0);

    // one hit per swing, re-arm after leaving attack states
    do_reset(); setup_basic();
    n = 0;
    for (int i = 0; i < 5; i++) begin step(1); n += int'(bus.p2_hit_pulse); end
    chk("req029_one_pulse", 32'(n), 1);
    bus.p1_state = 4'd0;
    repeat (20) step(1);
    bus.p1_state = 4'd4;
    step(1);
    chk("req029_second_hit", 32'({bus.hitresult, bus.p2_hit_pulse}), 32'b101);

    // clash
    do_reset(); clear_inputs();
    bus.p1_state = 4'd4; bus.p2_state = 4'd4;
    bus.p1_hitbox = {mk(0, 0, 0, 0), mk(100, 140, 50, 80)}; bus.p1_hitbox_valid = 2'b01;
    bus.p2_hitbox = {mk(0, 0, 0, 0), mk(130, 170, 60, 90)}; bus.p2_hitbox_valid = 2'b01;
    step(1);
    chk("req030_result", 32'(bus.hitresult), 32'h3);
    chk("req030_clash", 32'(bus.clash_pulse), 1);
    chk("req030_stun", 32'({bus.p1_stun, bus.p2_stun}), 0);

    // defender in pull state is targeted by its hitboxes; malformed box
    bus.p2_state = 4'd5;
    do_reset();
    step(1);
    chk("req031_vs_pull", 32'(bus.hitresult), 32'h2);
    do_reset(); clear_inputs();
    bus.p1_state = 4'd4;
    bus.p1_hitbox = {mk(0, 0, 0, 0), mk(200, 150, 50, 80)}; bus.p1_hitbox_valid = 2'b01;
    bus.p2_hurtbox = mk(100, 300, 0, 500);
    step(1);
    chk("req031_bad_box", 32'(bus.hitresult), 0);

    // per-box valid
    do_reset(); setup_basic();
    bus.p1_hitbox = {mk(100, 140, 50, 80), mk(100, 140, 50, 80)};
    bus.p1_hitbox_valid = 2'b10;
    step(1);
    chk("req032_box1", 32'(bus.hitresult), 32'h2);
    do_reset();
    bus.p1_hitbox_valid = 2'b00;
    step(1);
    chk("req032_none_valid", 32'(bus.hitresult), 0);

    // asynchronous reset mid-stun while SPENT
    do_reset(); setup_basic();
    repeat (10) step(1);
    chk("req033_still_stunned", 32'(bus.p2_stun), 1);
    #1 rst_n = 0;
    #1;
    chk("req033_async_stun", 32'({bus.p1_stun, bus.p2_stun}), 0);
    chk("req033_async_result", 32'(bus.hitresult), 0);
    @(posedge clk); #2 rst_n = 1;
    step(1);
    chk("req033_hit_after_reset", 32'(bus.hitresult), 32'h2);

    // randomized frames against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 150) == 0) begin
        rst_n = 0;
        @(posedge clk); #2 rst_n = 1;
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.p1_state = rand_state();
        bus.p2_state = rand_state();
      end
      if ($urandom_range(0, 1) == 0) begin
        bus.p1_hitbox = {rand_box(), rand_box()};
        bus.p2_hitbox = {rand_box(), rand_box()};
        bus.p1_hitbox_valid = 2'($urandom_range(0, 3));
        bus.p2_hitbox_valid = 2'($urandom_range(0, 3));
        bus.p1_hurtbox = rand_box();
        bus.p2_hurtbox = rand_box();
      end
      step(bit'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hit_resolver.md
HIT_RESOLVER -- requirements
Module: hit_resolver

Interface
REQ-001 Parameter: COORD_W, 10, coordinate width in bits.
REQ-002 Parameter: NBOX, 2, hitboxes per player (1..8).
REQ-003 Parameter: STATE_W, 4, player state width.
REQ-004 Parameter: STUN_FRAMES, 16, hitstun length in frame ticks (1..255).
REQ-005 Port: clk  in  1  the single clock; all registers on its rising edge.
REQ-006 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port: frame_tick  in  1  one-cycle frame strobe; inputs are evaluated only on this cycle.
REQ-008 Port: p1_state, p2_state  in  STATE_W  player FSM state (3 = B_ATTACK_START, 4 = B_ATTACK_END, 5 = B_ATTACK_PULL).
REQ-009 Port: p1_hitbox, p2_hitbox  in  NBOX*4*COORD_W  packed boxes; box i = {x1,x2,y1,y2} at bits [(i+1)*4*COORD_W-1 : i*4*COORD_W], x1 in the MSBs.
REQ-010 Port: p1_hitbox_valid, p2_hitbox_valid  in  NBOX  per-box enable.
REQ-011 Port: p1_hurtbox, p2_hurtbox  in  4*COORD_W  main hurtbox {x1,x2,y1,y2}.
REQ-012 Port: hitresult  out  2  registered result: 10 = P1 hits P2, 01 = P2 hits P1, 11 = clash, 00 = none.
REQ-013 Port: p1_hit_pulse, p2_hit_pulse, clash_pulse  out  1  one-cycle event strobes (p1_hit_pulse = P1 was hit).
REQ-014 Port: p1_stun, p2_stun  out  1  player is in hitstun.

Function
REQ-015 Overlap SHALL be unsigned and inclusive: a.x1<=b.x2 & b.x1<=a.x2 & a.y1<=b.y2 & b.y1<=a.y2; any box with x1>x2 or y1>y2 SHALL never overlap.
REQ-016 Target of an attack on player Q SHALL be Q's valid hitboxes when Q_state is 4 or 5, otherwise Q's hurtbox.
REQ-017 Player P "connects" on a tick iff P_state==4, P's attack FSM is ARMED, the opponent's stun is 0, and any valid P hitbox overlaps the target.
REQ-018 Per-player attack FSM SHALL have states ARMED and SPENT; ARMED->SPENT on a tick where P connects; SPENT->ARMED on a tick where P_state is not 3, 4 or 5; otherwise hold.
REQ-019 Only P1 connects -> hitresult=10, p2_hit_pulse=1, p2 stun counter loaded with STUN_FRAMES; symmetric for P2 only (01, p1_hit_pulse).
REQ-020 Both connect on the same tick -> hitresult=11, clash_pulse=1, both FSMs go SPENT, no stun loaded, no hit pulses.
REQ-021 Neither connects -> hitresult=00 on that tick.
REQ-022 Outputs SHALL update on the clk edge that samples frame_tick=1 (one-cycle latency); hitresult holds between ticks; pulses are high for exactly that one cycle.
REQ-023 Stun counters SHALL be 8 bits, decrement by 1 per tick while nonzero, saturate at 0; p*_stun = (counter != 0).
REQ-024 A stun load SHALL override the decrement on the same tick; a stunned player cannot be hit, but can still attack.
REQ-025 frame_tick=0 SHALL leave all state and hitresult unchanged and drive the pulses low.

Reset
REQ-026 rst_n=0 SHALL immediately clear hitresult, all pulses, and stun counters to 0, and set both FSMs to ARMED, including mid-attack or mid-stun.
REQ-027 After rst_n deasserts, the first evaluation SHALL occur on the first subsequent frame_tick.

Verification
REQ-028 P1 state 4, box0 {100,140,50,80} valid, P2 state 0, hurtbox {140,180,40,120}, tick -> hitresult=10, p2_hit_pulse for 1 cycle, p2_stun=1 for 16 ticks.
REQ-029 Same as REQ-028, but P1 held in state 4 for 5 ticks -> exactly one p2_hit_pulse; after P1 goes to state 0 and then back to state 4 on a later tick (P2 no longer stunned) -> second hit.
REQ-030 Both in state 4 with P1 box {100,140,50,80} and P2 box {130,170,60,90} -> hitresult=11, clash_pulse=1, both stun=0.
REQ-031 P1 state 4, P2 state 5 with overlapping hitboxes -> 10; P1 box with x1=200 > x2=150 -> 00.
REQ-032 Only box1 valid and overlapping (box0 invalid but overlapping) -> hit detected via box1 alone; all valid bits cleared -> 00.
REQ-033 rst_n asserted at stun count 7 while FSM is SPENT -> stun=0, hitresult=00 without any clk edge; next tick with overlap -> hit.
